// File: rtl/uart_rx_fifo_if.sv
// Byte-stream bundle between the UART receiver/host side and the receive FIFO.
interface uart_rx_fifo_if #(
    parameter int unsigned DEPTH_LOG2 = 4
);
    logic                  rx_end;
    logic [7:0]            rx_data;
    logic                  pop;
    logic                  flush;
    logic                  ovr_clr;
    logic [7:0]            rd_data;
    logic                  empty;
    logic                  full;
    logic [DEPTH_LOG2:0]   count;
    logic                  overrun;
    logic                  timeout;
    logic                  irq_rx;

    modport master (
        output rx_end, rx_data, pop, flush, ovr_clr,
        input  rd_data, empty, full, count, overrun, timeout, irq_rx
    );

    modport slave (
        input  rx_end, rx_data, pop, flush, ovr_clr,
        output rd_data, empty, full, count, overrun, timeout, irq_rx
    );
endinterface

// File: rtl/uart_rx_fifo.sv
// Receive FWFT byte FIFO with sticky overrun, idle timeout and a combined
// level/timeout interrupt.
module uart_rx_fifo #(
    parameter int unsigned DEPTH_LOG2     = 4,
    parameter int unsigned THRESH         = 8,
    parameter int unsigned TIMEOUT_CYCLES = 2048
) (
    input  logic            clk,
    input  logic            reset,
    uart_rx_fifo_if.slave   rx_if
);
    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam int unsigned PW    = DEPTH_LOG2;
    localparam int unsigned CW    = DEPTH_LOG2 + 1;
    localparam int unsigned TW    = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic {
        TO_IDLE,
        TO_EXPIRED
    } to_state_e;

    logic [7:0]    mem_q [DEPTH];
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [TW-1:0] tcnt_q, tcnt_d;
    to_state_e     state_q, state_d;
    logic          overrun_q, overrun_d;
    logic          irq_q, irq_d;

    logic          empty_c, full_c;
    logic          push_acc, pop_acc, drop;

    assign empty_c = (count_q == '0);
    assign full_c  = (count_q == CW'(DEPTH));

    // State register; storage array is left unreset on purpose.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            count_q   <= '0;
            tcnt_q    <= '0;
            state_q   <= TO_IDLE;
            overrun_q <= 1'b0;
            irq_q     <= 1'b0;
        end else begin
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            count_q   <= count_d;
            tcnt_q    <= tcnt_d;
            state_q   <= state_d;
            overrun_q <= overrun_d;
            irq_q     <= irq_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && push_acc) begin
            mem_q[wr_ptr_q] <= rx_if.rx_data;
        end
    end

    // Next-state: flush beats push/pop; a pop frees room for a push into a full FIFO.
    always_comb begin
        rd_ptr_d  = rd_ptr_q;
        wr_ptr_d  = wr_ptr_q;
        count_d   = count_q;
        tcnt_d    = tcnt_q;
        state_d   = state_q;
        overrun_d = overrun_q & ~rx_if.ovr_clr;
        irq_d     = 1'b0;
        push_acc  = 1'b0;
        pop_acc   = 1'b0;
        drop      = 1'b0;

        if (rx_if.flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            pop_acc  = rx_if.pop & ~empty_c;
            push_acc = rx_if.rx_end & (~full_c | pop_acc);
            drop     = rx_if.rx_end & ~push_acc;
            if (pop_acc) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            if (push_acc) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
            end
            count_d = count_q + CW'(push_acc) - CW'(pop_acc);
        end

        if (drop) begin
            overrun_d = 1'b1;
        end

        // Idle timeout: any accepted activity or an empty FIFO restarts the count.
        if (rx_if.flush || push_acc || pop_acc || empty_c) begin
            tcnt_d  = '0;
            state_d = TO_IDLE;
        end else begin
            if (tcnt_q != TW'(TIMEOUT_CYCLES)) begin
                tcnt_d = tcnt_q + TW'(1);
            end
            if (state_q == TO_IDLE && tcnt_d == TW'(TIMEOUT_CYCLES)) begin
                state_d = TO_EXPIRED;
            end
        end

        irq_d = (count_d >= CW'(THRESH)) | (state_d == TO_EXPIRED);
    end

    assign rx_if.rd_data = empty_c ? 8'h00 : mem_q[rd_ptr_q];
    assign rx_if.empty   = empty_c;
    assign rx_if.full    = full_c;
    assign rx_if.count   = count_q;
    assign rx_if.overrun = overrun_q;
    assign rx_if.timeout = (state_q == TO_EXPIRED);
    assign rx_if.irq_rx  = irq_q;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo (depth 16, threshold 8, timeout 16 cycles).
module tb_uart_rx_fifo;
    logic clk;
    logic reset;
    int   checks;
    int   errors;

    uart_rx_fifo_if #(.DEPTH_LOG2(4)) rx_if ();

    uart_rx_fifo #(
        .DEPTH_LOG2    (4),
        .THRESH        (8),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .rx_if(rx_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [7:0] b);
        rx_if.rx_end  = 1'b1;
        rx_if.rx_data = b;
        tick();
        rx_if.rx_end  = 1'b0;
    endtask

    task automatic do_pop();
        rx_if.pop = 1'b1;
        tick();
        rx_if.pop = 1'b0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, " empty"},   32'(rx_if.empty),   32'd1);
        chk({tag, " full"},    32'(rx_if.full),    32'd0);
        chk({tag, " count"},   32'(rx_if.count),   32'd0);
        chk({tag, " rd_data"}, 32'(rx_if.rd_data), 32'h00);
        chk({tag, " overrun"}, 32'(rx_if.overrun), 32'd0);
        chk({tag, " timeout"}, 32'(rx_if.timeout), 32'd0);
        chk({tag, " irq_rx"},  32'(rx_if.irq_rx),  32'd0);
    endtask

    logic [7:0] model_q[$];
    logic [7:0] nb;
    logic       dpush, dpop;

    initial begin
        checks = 0;
        errors = 0;
        reset          = 1'b1;
        rx_if.rx_end   = 1'b0;
        rx_if.rx_data  = 8'h00;
        rx_if.pop      = 1'b0;
        rx_if.flush    = 1'b0;
        rx_if.ovr_clr  = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        chk_reset_vals("reset");

        // Push three, drain three, then a pop on empty is ignored.
        push(8'h41);
        push(8'h42);
        push(8'h43);
        chk("p3 count", 32'(rx_if.count), 32'd3);
        chk("p3 head",  32'(rx_if.rd_data), 32'h41);
        do_pop();
        chk("pop1 head", 32'(rx_if.rd_data), 32'h42);
        do_pop();
        chk("pop2 head", 32'(rx_if.rd_data), 32'h43);
        do_pop();
        chk("pop3 empty", 32'(rx_if.empty), 32'd1);
        chk("pop3 rd",    32'(rx_if.rd_data), 32'h00);
        do_pop();
        chk("pop_empty count", 32'(rx_if.count), 32'd0);
        chk("pop_empty ovr",   32'(rx_if.overrun), 32'd0);

        // Overrun: 17 pushes into 16 entries.
        for (int i = 0; i < 17; i++) begin
            if (i == 16) begin
                chk("pre-drop ovr", 32'(rx_if.overrun), 32'd0);
            end
            push(8'(i));
        end
        chk("ovr full",  32'(rx_if.full), 32'd1);
        chk("ovr count", 32'(rx_if.count), 32'd16);
        chk("ovr flag",  32'(rx_if.overrun), 32'd1);
        chk("ovr head",  32'(rx_if.rd_data), 32'h00);
        chk("ovr irq",   32'(rx_if.irq_rx), 32'd1);
        rx_if.ovr_clr = 1'b1;
        tick();
        chk("ovr_clr", 32'(rx_if.overrun), 32'd0);
        rx_if.rx_end  = 1'b1;
        rx_if.rx_data = 8'h99;
        tick();
        rx_if.rx_end  = 1'b0;
        chk("ovr_clr+drop", 32'(rx_if.overrun), 32'd1);
        chk("ovr_clr+drop count", 32'(rx_if.count), 32'd16);
        tick();
        rx_if.ovr_clr = 1'b0;
        chk("ovr_clr2", 32'(rx_if.overrun), 32'd0);

        // Push+pop while full: no overrun, count stays 16, order kept.
        rx_if.rx_end  = 1'b1;
        rx_if.rx_data = 8'h10;
        rx_if.pop     = 1'b1;
        tick();
        rx_if.rx_end  = 1'b0;
        rx_if.pop     = 1'b0;
        chk("full pp count", 32'(rx_if.count), 32'd16);
        chk("full pp ovr",   32'(rx_if.overrun), 32'd0);
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("drain %0d", i), 32'(rx_if.rd_data), 32'(i + 1));
            do_pop();
        end
        chk("drain empty", 32'(rx_if.empty), 32'd1);

        // Push+pop while empty: push only.
        rx_if.rx_end  = 1'b1;
        rx_if.rx_data = 8'h5A;
        rx_if.pop     = 1'b1;
        tick();
        rx_if.rx_end  = 1'b0;
        rx_if.pop     = 1'b0;
        chk("empty pp count", 32'(rx_if.count), 32'd1);
        chk("empty pp head",  32'(rx_if.rd_data), 32'h5A);
        do_pop();
        chk("empty pp drained", 32'(rx_if.empty), 32'd1);

        // Wrap-around with mixed push/pop against a queue model.
        for (int i = 0; i < 5; i++) begin
            nb = 8'(8'hA0 + i);
            push(nb);
            model_q.push_back(nb);
        end
        for (int i = 0; i < 60; i++) begin
            chk($sformatf("wrap head %0d", i), 32'(rx_if.rd_data), 32'(model_q[0]));
            chk($sformatf("wrap count %0d", i), 32'(rx_if.count), 32'(model_q.size()));
            dpush = (i % 4) != 3;
            dpop  = ((i % 4) != 0) && (model_q.size() > 1);
            nb    = 8'(i * 7 + 3);
            rx_if.rx_end  = dpush;
            rx_if.rx_data = nb;
            rx_if.pop     = dpop;
            tick();
            rx_if.rx_end  = 1'b0;
            rx_if.pop     = 1'b0;
            if (dpop) void'(model_q.pop_front());
            if (dpush) model_q.push_back(nb);
        end
        while (model_q.size() > 0) begin
            chk("wrap drain", 32'(rx_if.rd_data), 32'(model_q[0]));
            do_pop();
            void'(model_q.pop_front());
        end
        chk("wrap empty", 32'(rx_if.empty), 32'd1);

        // Threshold and timeout.
        for (int i = 0; i < 7; i++) push(8'(8'h70 + i));
        chk("thr7 count", 32'(rx_if.count), 32'd7);
        chk("thr7 irq",   32'(rx_if.irq_rx), 32'd0);
        push(8'h77);
        chk("thr8 count", 32'(rx_if.count), 32'd8);
        chk("thr8 irq",   32'(rx_if.irq_rx), 32'd1);
        for (int i = 0; i < 7; i++) do_pop();
        chk("to count1", 32'(rx_if.count), 32'd1);
        chk("to irq0",   32'(rx_if.irq_rx), 32'd0);
        for (int i = 0; i < 15; i++) tick();
        chk("to 15 idle", 32'(rx_if.timeout), 32'd0);
        tick();
        chk("to 16 idle", 32'(rx_if.timeout), 32'd1);
        chk("to irq",     32'(rx_if.irq_rx), 32'd1);
        do_pop();
        chk("to cleared", 32'(rx_if.timeout), 32'd0);
        chk("to irq clr", 32'(rx_if.irq_rx), 32'd0);

        // Flush beats a simultaneous push.
        push(8'h11);
        push(8'h22);
        rx_if.flush   = 1'b1;
        rx_if.rx_end  = 1'b1;
        rx_if.rx_data = 8'h33;
        tick();
        rx_if.flush   = 1'b0;
        rx_if.rx_end  = 1'b0;
        chk("flush count", 32'(rx_if.count), 32'd0);
        chk("flush rd",    32'(rx_if.rd_data), 32'h00);
        chk("flush ovr",   32'(rx_if.overrun), 32'd0);
        push(8'h44);
        chk("post flush head",  32'(rx_if.rd_data), 32'h44);
        chk("post flush count", 32'(rx_if.count), 32'd1);

        // Reset in the middle of a push burst with overrun pending.
        for (int i = 0; i < 17; i++) push(8'(8'hC0 + i));
        chk("pre-reset ovr", 32'(rx_if.overrun), 32'd1);
        reset         = 1'b1;
        rx_if.rx_end  = 1'b1;
        rx_if.rx_data = 8'hEE;
        rx_if.pop     = 1'b1;
        tick();
        reset         = 1'b0;
        rx_if.rx_end  = 1'b0;
        rx_if.pop     = 1'b0;
        chk_reset_vals("mid reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
